// File: rtl/kd_node_sort_ctrl.sv
// kd-tree node controller: holds one DIM-dimensional cluster center, handles
// depth/axis configuration with child-ack aggregation, an odd-even swap sort
// along the node's split axis, and the stop/ack drain. Every command output is
// registered, so a response appears the cycle after the event that caused it.
module kd_node_sort_ctrl #(
  parameter int DIM          = 2,
  parameter int COORD_W      = 16,
  parameter int DEPTH_W      = 4,
  parameter bit HAS_CHILDREN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alert_from_top,
  input  logic                   alert_from_left,
  input  logic                   alert_from_right,
  input  logic [2:0]             cmd_from_top,
  input  logic [2:0]             cmd_from_left,
  input  logic [2:0]             cmd_from_right,
  input  logic [DIM*COORD_W-1:0] data_from_top,
  input  logic [DIM*COORD_W-1:0] data_from_left,
  input  logic [DIM*COORD_W-1:0] data_from_right,
  output logic                   alert_to_top,
  output logic                   alert_to_left,
  output logic                   alert_to_right,
  output logic [2:0]             cmd_to_top,
  output logic [2:0]             cmd_to_left,
  output logic [2:0]             cmd_to_right,
  output logic [DIM*COORD_W-1:0] data_to_top,
  output logic [DIM*COORD_W-1:0] data_to_left,
  output logic [DIM*COORD_W-1:0] data_to_right,
  output logic                   node_stable,
  output logic [2:0]             state_o
);

  localparam int DATA_W = DIM * COORD_W;

  localparam logic [2:0] CMD_NOP        = 3'd0;
  localparam logic [2:0] CMD_LOAD       = 3'd1;
  localparam logic [2:0] CMD_CONFIG     = 3'd2;
  localparam logic [2:0] CMD_CFG_ACK    = 3'd3;
  localparam logic [2:0] CMD_SORT_START = 3'd4;
  localparam logic [2:0] CMD_SWAP       = 3'd5;
  localparam logic [2:0] CMD_SORT_STOP  = 3'd6;
  localparam logic [2:0] CMD_STOP_ACK   = 3'd7;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd1;
  localparam logic [2:0] ST_READY     = 3'd2;
  localparam logic [2:0] ST_SORT      = 3'd3;
  localparam logic [2:0] ST_STOP_WAIT = 3'd4;

  // Extract the coordinate selected by the split axis from a packed center.
  function automatic logic [COORD_W-1:0] key_of(input logic [DATA_W-1:0] d, input int ax);
    logic [COORD_W-1:0] k;
    k = '0;
    for (int i = 0; i < DIM; i++) begin
      k = (ax == i) ? d[i*COORD_W +: COORD_W] : k;
    end
    return k;
  endfunction

  logic [2:0]         state_r, state_nxt_s;
  logic [DATA_W-1:0]  center_r, center_nxt_s;
  logic [DEPTH_W-1:0] depth_r, depth_nxt_s;
  logic               phase_r, phase_nxt_s;
  logic               ack_left_r, ack_left_nxt_s;
  logic               ack_right_r, ack_right_nxt_s;
  logic               stable_r, stable_nxt_s;

  logic               alert_top_r, alert_top_nxt_s;
  logic [2:0]         cmd_top_r, cmd_top_nxt_s;
  logic               alert_left_r, alert_left_nxt_s;
  logic [2:0]         cmd_left_r, cmd_left_nxt_s;
  logic [DATA_W-1:0]  data_left_r, data_left_nxt_s;
  logic               alert_right_r, alert_right_nxt_s;
  logic [2:0]         cmd_right_r, cmd_right_nxt_s;
  logic [DATA_W-1:0]  data_right_r, data_right_nxt_s;

  logic [2:0]         top_cmd_s, left_cmd_s, right_cmd_s, wait_ack_s;
  logic [DEPTH_W-1:0] depth_inc_s;
  logic [COORD_W-1:0] self_key_s, left_key_s, right_key_s;
  int                 axis_s;

  assign axis_s      = int'(depth_r) % DIM;
  assign self_key_s  = key_of(center_r, axis_s);
  assign left_key_s  = key_of(data_from_left, axis_s);
  assign right_key_s = key_of(data_from_right, axis_s);
  assign depth_inc_s = data_from_top[DEPTH_W-1:0] + DEPTH_W'(1'b1);

  // Qualify incoming commands with their alert; leaves never listen to children.
  always_comb begin
    top_cmd_s   = alert_from_top ? cmd_from_top : CMD_NOP;
    left_cmd_s  = (HAS_CHILDREN && alert_from_left) ? cmd_from_left : CMD_NOP;
    right_cmd_s = (HAS_CHILDREN && alert_from_right) ? cmd_from_right : CMD_NOP;
    wait_ack_s  = (state_r == ST_CFG_WAIT) ? CMD_CFG_ACK : CMD_STOP_ACK;
  end

  // Next-state and next-output decision for the node FSM.
  always_comb begin
    state_nxt_s       = state_r;
    center_nxt_s      = center_r;
    depth_nxt_s       = depth_r;
    phase_nxt_s       = phase_r;
    ack_left_nxt_s    = ack_left_r;
    ack_right_nxt_s   = ack_right_r;
    stable_nxt_s      = stable_r;
    alert_top_nxt_s   = 1'b0;
    cmd_top_nxt_s     = CMD_NOP;
    alert_left_nxt_s  = 1'b0;
    cmd_left_nxt_s    = CMD_NOP;
    data_left_nxt_s   = '0;
    alert_right_nxt_s = 1'b0;
    cmd_right_nxt_s   = CMD_NOP;
    data_right_nxt_s  = '0;

    case (state_r)
      ST_IDLE, ST_READY: begin
        if (top_cmd_s == CMD_LOAD) begin
          center_nxt_s = data_from_top;
        end else if (top_cmd_s == CMD_CONFIG) begin
          depth_nxt_s = data_from_top[DEPTH_W-1:0];
          if (HAS_CHILDREN) begin
            alert_left_nxt_s  = 1'b1;
            cmd_left_nxt_s    = CMD_CONFIG;
            data_left_nxt_s   = DATA_W'(depth_inc_s);
            alert_right_nxt_s = 1'b1;
            cmd_right_nxt_s   = CMD_CONFIG;
            data_right_nxt_s  = DATA_W'(depth_inc_s);
            ack_left_nxt_s    = 1'b0;
            ack_right_nxt_s   = 1'b0;
            state_nxt_s       = ST_CFG_WAIT;
          end else begin
            alert_top_nxt_s = 1'b1;
            cmd_top_nxt_s   = CMD_CFG_ACK;
            state_nxt_s     = ST_READY;
          end
        end else if ((top_cmd_s == CMD_SORT_START) && (state_r == ST_READY)) begin
          if (HAS_CHILDREN) begin
            alert_left_nxt_s  = 1'b1;
            cmd_left_nxt_s    = CMD_SORT_START;
            alert_right_nxt_s = 1'b1;
            cmd_right_nxt_s   = CMD_SORT_START;
          end else begin
            alert_left_nxt_s  = 1'b0;
          end
          phase_nxt_s = 1'b0;
          state_nxt_s = ST_SORT;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ST_CFG_WAIT, ST_STOP_WAIT: begin
        // Acks are sticky so the two children may answer in any order or together.
        ack_left_nxt_s  = ack_left_r | (left_cmd_s == wait_ack_s);
        ack_right_nxt_s = ack_right_r | (right_cmd_s == wait_ack_s);
        if (ack_left_nxt_s && ack_right_nxt_s) begin
          alert_top_nxt_s = 1'b1;
          cmd_top_nxt_s   = wait_ack_s;
          ack_left_nxt_s  = 1'b0;
          ack_right_nxt_s = 1'b0;
          state_nxt_s     = ST_READY;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ST_SORT: begin
        phase_nxt_s = ~phase_r;
        if (top_cmd_s == CMD_SORT_STOP) begin
          // Stopping wins over any swap that would have happened this cycle.
          if (HAS_CHILDREN) begin
            alert_left_nxt_s  = 1'b1;
            cmd_left_nxt_s    = CMD_SORT_STOP;
            alert_right_nxt_s = 1'b1;
            cmd_right_nxt_s   = CMD_SORT_STOP;
            ack_left_nxt_s    = 1'b0;
            ack_right_nxt_s   = 1'b0;
            state_nxt_s       = ST_STOP_WAIT;
          end else begin
            alert_top_nxt_s = 1'b1;
            cmd_top_nxt_s   = CMD_STOP_ACK;
            state_nxt_s     = ST_READY;
          end
        end else if (phase_r) begin
          // Passive cycle: only the parent may exchange with us.
          if (top_cmd_s == CMD_SWAP) begin
            center_nxt_s = data_from_top;
            stable_nxt_s = 1'b0;
          end else begin
            stable_nxt_s = stable_r;
          end
        end else if (HAS_CHILDREN) begin
          // Active cycle: left child holds keys >= ours, right child keys <= ours.
          if (left_key_s > self_key_s) begin
            alert_left_nxt_s = 1'b1;
            cmd_left_nxt_s   = CMD_SWAP;
            data_left_nxt_s  = center_r;
            center_nxt_s     = data_from_left;
            stable_nxt_s     = 1'b0;
          end else if (right_key_s < self_key_s) begin
            alert_right_nxt_s = 1'b1;
            cmd_right_nxt_s   = CMD_SWAP;
            data_right_nxt_s  = center_r;
            center_nxt_s      = data_from_right;
            stable_nxt_s      = 1'b0;
          end else begin
            stable_nxt_s = 1'b1;
          end
        end else begin
          stable_nxt_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, center and registered link outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      center_r      <= '0;
      depth_r       <= '0;
      phase_r       <= 1'b0;
      ack_left_r    <= 1'b0;
      ack_right_r   <= 1'b0;
      stable_r      <= 1'b0;
      alert_top_r   <= 1'b0;
      cmd_top_r     <= CMD_NOP;
      alert_left_r  <= 1'b0;
      cmd_left_r    <= CMD_NOP;
      data_left_r   <= '0;
      alert_right_r <= 1'b0;
      cmd_right_r   <= CMD_NOP;
      data_right_r  <= '0;
    end else begin
      state_r       <= state_nxt_s;
      center_r      <= center_nxt_s;
      depth_r       <= depth_nxt_s;
      phase_r       <= phase_nxt_s;
      ack_left_r    <= ack_left_nxt_s;
      ack_right_r   <= ack_right_nxt_s;
      stable_r      <= stable_nxt_s;
      alert_top_r   <= alert_top_nxt_s;
      cmd_top_r     <= cmd_top_nxt_s;
      alert_left_r  <= alert_left_nxt_s;
      cmd_left_r    <= cmd_left_nxt_s;
      data_left_r   <= data_left_nxt_s;
      alert_right_r <= alert_right_nxt_s;
      cmd_right_r   <= cmd_right_nxt_s;
      data_right_r  <= data_right_nxt_s;
    end
  end

  assign alert_to_top   = alert_top_r;
  assign cmd_to_top     = cmd_top_r;
  assign data_to_top    = center_r;
  assign alert_to_left  = alert_left_r;
  assign cmd_to_left    = cmd_left_r;
  assign data_to_left   = data_left_r;
  assign alert_to_right = alert_right_r;
  assign cmd_to_right   = cmd_right_r;
  assign data_to_right  = data_right_r;
  assign node_stable    = stable_r;
  assign state_o        = state_r;

endmodule

// File: tb/tb_kd_node_sort_ctrl.sv
// Directed bench for kd_node_sort_ctrl: one inner node (DIM=2, COORD_W=16)
// with the bench playing parent and both children, plus one leaf instance.
module tb_kd_node_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        top_alert, l_alert, r_alert;
  logic [2:0]  top_cmd, l_cmd, r_cmd;
  logic [31:0] top_data, l_data, r_data;
  logic        o_top_alert, o_l_alert, o_r_alert, o_stable;
  logic [2:0]  o_top_cmd, o_l_cmd, o_r_cmd, o_state;
  logic [31:0] o_top_data, o_l_data, o_r_data;

  logic        lf_alert;
  logic [2:0]  lf_cmd;
  logic [31:0] lf_data;
  logic        z_alert;
  logic [2:0]  z_cmd;
  logic [31:0] z_data;
  logic        lf_o_top_alert, lf_o_l_alert, lf_o_r_alert, lf_o_stable;
  logic [2:0]  lf_o_top_cmd, lf_o_l_cmd, lf_o_r_cmd, lf_o_state;
  logic [31:0] lf_o_top_data, lf_o_l_data, lf_o_r_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  kd_node_sort_ctrl #(.DIM(2), .COORD_W(16), .DEPTH_W(4), .HAS_CHILDREN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alert_from_top(top_alert), .alert_from_left(l_alert), .alert_from_right(r_alert),
    .cmd_from_top(top_cmd), .cmd_from_left(l_cmd), .cmd_from_right(r_cmd),
    .data_from_top(top_data), .data_from_left(l_data), .data_from_right(r_data),
    .alert_to_top(o_top_alert), .alert_to_left(o_l_alert), .alert_to_right(o_r_alert),
    .cmd_to_top(o_top_cmd), .cmd_to_left(o_l_cmd), .cmd_to_right(o_r_cmd),
    .data_to_top(o_top_data), .data_to_left(o_l_data), .data_to_right(o_r_data),
    .node_stable(o_stable), .state_o(o_state)
  );

  kd_node_sort_ctrl #(.DIM(2), .COORD_W(16), .DEPTH_W(4), .HAS_CHILDREN(1'b0)) leaf (
    .clk(clk), .rst(rst),
    .alert_from_top(lf_alert), .alert_from_left(z_alert), .alert_from_right(z_alert),
    .cmd_from_top(lf_cmd), .cmd_from_left(z_cmd), .cmd_from_right(z_cmd),
    .data_from_top(lf_data), .data_from_left(z_data), .data_from_right(z_data),
    .alert_to_top(lf_o_top_alert), .alert_to_left(lf_o_l_alert), .alert_to_right(lf_o_r_alert),
    .cmd_to_top(lf_o_top_cmd), .cmd_to_left(lf_o_l_cmd), .cmd_to_right(lf_o_r_cmd),
    .data_to_top(lf_o_top_data), .data_to_left(lf_o_l_data), .data_to_right(lf_o_r_data),
    .node_stable(lf_o_stable), .state_o(lf_o_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; strobes last exactly one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    top_alert = 1'b0; top_cmd = 3'd0;
    l_alert   = 1'b0; l_cmd   = 3'd0;
    r_alert   = 1'b0; r_cmd   = 3'd0;
    lf_alert  = 1'b0; lf_cmd  = 3'd0;
  endtask

  initial begin
    rst = 1'b0;
    top_alert = 1'b0; top_cmd = 3'd0; top_data = 32'd0;
    l_alert = 1'b0; l_cmd = 3'd0; l_data = 32'd0;
    r_alert = 1'b0; r_cmd = 3'd0; r_data = 32'd0;
    lf_alert = 1'b0; lf_cmd = 3'd0; lf_data = 32'd0;
    z_alert = 1'b0; z_cmd = 3'd0; z_data = 32'd0;

    // Reset values
    #2;
    check_eq("rst_state", o_state, 3'd0);
    check_eq("rst_outs", {o_top_alert, o_l_alert, o_r_alert, o_top_cmd, o_l_cmd, o_r_cmd}, 12'd0);
    check_eq("rst_data", {o_top_data, o_l_data}, 64'd0);
    check_eq("rst_stable", o_stable, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // CONFIG depth 3: children get depth 4, acks at t+2 and t+5, CFG_ACK at t+6
    top_alert = 1'b1; top_cmd = 3'd2; top_data = 32'd3;
    step();
    check_eq("cfg_fwd_left", {o_l_alert, o_l_cmd}, {1'b1, 3'd2});
    check_eq("cfg_fwd_right", {o_r_alert, o_r_cmd}, {1'b1, 3'd2});
    check_eq("cfg_data", {o_l_data, o_r_data}, {32'd4, 32'd4});
    check_eq("cfg_wait_state", o_state, 3'd1);
    step();
    check_eq("cfg_fwd_pulse", {o_l_alert, o_l_data}, 33'd0);
    l_alert = 1'b1; l_cmd = 3'd3;
    step();
    check_eq("cfg_one_ack", o_top_alert, 1'b0);
    step();
    step();
    r_alert = 1'b1; r_cmd = 3'd3;
    step();
    check_eq("cfg_ack_top", {o_top_alert, o_top_cmd}, {1'b1, 3'd3});
    check_eq("cfg_ready", o_state, 3'd2);
    step();
    check_eq("cfg_ack_single", o_top_alert, 1'b0);

    // Re-CONFIG from READY with depth 15 (child depth wraps to 0), then reset mid-wait
    top_alert = 1'b1; top_cmd = 3'd2; top_data = 32'd15;
    step();
    check_eq("wrap_fwd", {o_l_alert, o_l_data}, {1'b1, 32'd0});
    check_eq("wrap_state", o_state, 3'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst_state", o_state, 3'd0);
    check_eq("midrst_outs", {o_top_alert, o_l_alert, o_r_alert, o_l_cmd, o_r_cmd}, 9'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    l_alert = 1'b1; l_cmd = 3'd3; r_alert = 1'b1; r_cmd = 3'd3;
    step();
    check_eq("midrst_ack_ign", {o_top_alert, o_state}, {1'b0, 3'd0});

    // CONFIG depth 0 with both acks in the same cycle
    top_alert = 1'b1; top_cmd = 3'd2; top_data = 32'd0;
    step();
    l_alert = 1'b1; l_cmd = 3'd3; r_alert = 1'b1; r_cmd = 3'd3;
    step();
    check_eq("same_ack_top", {o_top_alert, o_top_cmd, o_state}, {1'b1, 3'd3, 3'd2});

    // LOAD center (x=5,y=9); no response
    top_alert = 1'b1; top_cmd = 3'd1; top_data = 32'h0009_0005;
    step();
    check_eq("load_center", o_top_data, 32'h0009_0005);
    check_eq("load_noresp", {o_top_alert, o_l_alert}, 2'b00);

    // Sort, axis x: left x=8 > 5 swaps in first active cycle
    l_data = 32'h0001_0008; r_data = 32'h0003_000C;
    top_alert = 1'b1; top_cmd = 3'd4;
    step();
    check_eq("sort_fwd", {o_l_alert, o_l_cmd, o_r_alert, o_r_cmd, o_state}, {1'b1, 3'd4, 1'b1, 3'd4, 3'd3});
    step();
    check_eq("swap_left", {o_l_alert, o_l_cmd, o_l_data}, {1'b1, 3'd5, 32'h0009_0005});
    check_eq("swap_center", o_top_data, 32'h0001_0008);
    check_eq("swap_no_right", o_r_alert, 1'b0);
    check_eq("swap_unstable", o_stable, 1'b0);
    l_data = 32'h0009_0005;
    step();
    check_eq("passive_quiet", {o_l_alert, o_r_alert}, 2'b00);
    step();
    check_eq("stable_set", o_stable, 1'b1);
    check_eq("stable_center", o_top_data, 32'h0001_0008);

    // SWAP from parent in a passive cycle
    top_alert = 1'b1; top_cmd = 3'd5; top_data = 32'h0000_0007;
    step();
    check_eq("top_swap_center", o_top_data, 32'h0000_0007);
    check_eq("top_swap_unstable", o_stable, 1'b0);
    step();
    check_eq("restable", o_stable, 1'b1);

    // SORT_STOP in an active cycle that would otherwise swap with left (x=20)
    l_data = 32'h0000_0014;
    step();
    top_alert = 1'b1; top_cmd = 3'd6;
    step();
    check_eq("stop_fwd_left", {o_l_alert, o_l_cmd, o_l_data}, {1'b1, 3'd6, 32'd0});
    check_eq("stop_fwd_right", {o_r_alert, o_r_cmd}, {1'b1, 3'd6});
    check_eq("stop_wait", {o_state, o_top_data}, {3'd4, 32'h0000_0007});
    r_alert = 1'b1; r_cmd = 3'd7;
    step();
    check_eq("stop_one_ack", o_top_alert, 1'b0);
    l_alert = 1'b1; l_cmd = 3'd7;
    step();
    check_eq("stop_ack_top", {o_top_alert, o_top_cmd, o_state}, {1'b1, 3'd7, 3'd2});
    check_eq("stop_center", o_top_data, 32'h0000_0007);

    // Left priority: left 10 > 5 and right 2 < 5; right swap follows two cycles later
    top_alert = 1'b1; top_cmd = 3'd1; top_data = 32'h0000_0005;
    step();
    l_data = 32'h0000_000A; r_data = 32'h0000_0002;
    top_alert = 1'b1; top_cmd = 3'd4;
    step();
    step();
    check_eq("prio_left", {o_l_alert, o_l_cmd, o_l_data}, {1'b1, 3'd5, 32'h0000_0005});
    check_eq("prio_no_right", o_r_alert, 1'b0);
    check_eq("prio_center", o_top_data, 32'h0000_000A);
    l_data = 32'h0000_0005;
    step();
    check_eq("prio_passive", o_r_alert, 1'b0);
    step();
    check_eq("prio_right", {o_r_alert, o_r_cmd, o_r_data}, {1'b1, 3'd5, 32'h0000_000A});
    check_eq("prio_right_center", {o_top_data, o_l_alert}, {32'h0000_0002, 1'b0});

    // Leaf: CONFIG acked directly, re-accepted in READY, sort and stop
    lf_alert = 1'b1; lf_cmd = 3'd2; lf_data = 32'd0;
    step();
    check_eq("leaf_cfg_ack", {lf_o_top_alert, lf_o_top_cmd, lf_o_state}, {1'b1, 3'd3, 3'd2});
    check_eq("leaf_no_child", {lf_o_l_alert, lf_o_r_alert, lf_o_l_cmd, lf_o_l_data}, 37'd0);
    lf_alert = 1'b1; lf_cmd = 3'd2; lf_data = 32'd5;
    step();
    check_eq("leaf_recfg", {lf_o_top_alert, lf_o_top_cmd}, {1'b1, 3'd3});
    lf_alert = 1'b1; lf_cmd = 3'd4;
    step();
    check_eq("leaf_sort", {lf_o_state, lf_o_l_alert, lf_o_top_alert}, {3'd3, 1'b0, 1'b0});
    step();
    check_eq("leaf_stable", lf_o_stable, 1'b1);
    lf_alert = 1'b1; lf_cmd = 3'd6;
    step();
    check_eq("leaf_stop_ack", {lf_o_top_alert, lf_o_top_cmd, lf_o_state}, {1'b1, 3'd7, 3'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/kd_node_sort_ctrl.md
Name: kd_node_sort_ctrl

Overview:
- Parametrised next-generation kd-tree node controller.
- Holds one DIM-dimensional cluster center and talks to its parent (top) and two children (left, right) over alert/command/data links.
- Implements depth/axis configuration with child-ack aggregation, a deadlock-free odd-even swap sort along the node's split axis, and a stop/ack drain.
- One instance per tree node; leaves are built with HAS_CHILDREN=0.

Parameters:
DIM, 2, number of coordinates per center
COORD_W, 16, unsigned bits per coordinate
DEPTH_W, 4, bits of node depth field
HAS_CHILDREN, 1, 0 = leaf: child ports ignored, child outputs held NOP/0

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
alert_from_top / alert_from_left / alert_from_right  in  1  one-cycle command strobe from neighbour
cmd_from_top / cmd_from_left / cmd_from_right  in  3  command, valid only with alert
data_from_top / data_from_left / data_from_right  in  DIM*COORD_W  neighbour data (children present their center continuously)
alert_to_top / alert_to_left / alert_to_right  out  1  one-cycle command strobe
cmd_to_top / cmd_to_left / cmd_to_right  out  3  command; NOP(0) whenever alert low
data_to_top  out  DIM*COORD_W  always the current center register
data_to_left / data_to_right  out  DIM*COORD_W  payload of the outgoing command, else 0
node_stable  out  1  last own active sort cycle did no swap and no SWAP was received since
state_o  out  3  current FSM state, for debug

Behaviour:
- Commands: 0 NOP, 1 LOAD, 2 CONFIG, 3 CFG_ACK, 4 SORT_START, 5 SWAP, 6 SORT_STOP, 7 STOP_ACK.
- Command outputs are registered: a response is issued the cycle after its trigger.
- Reset (async, any time, including mid-sort): state=IDLE; center, depth, axis, phase, ack flags = 0; all alerts 0; cmds NOP; data_to_left/right 0; node_stable 0.
- Key = coordinate `axis` of a center. axis = depth mod DIM. Comparisons are unsigned.
- Unexpected command for the current state: ignored, no response.
- IDLE / READY, LOAD from top: center <= data_from_top. No response.
- IDLE / READY, CONFIG from top: depth <= data_from_top[DEPTH_W-1:0].
  - Leaf: pulse CFG_ACK to top, go READY.
  - Non-leaf: pulse CONFIG to both children with data = depth+1 (mod 2^DEPTH_W, zero-extended), go CFG_WAIT.
- CFG_WAIT: sticky flags record CFG_ACK from left and from right; acks may arrive in the same or different cycles. The cycle both flags are set: pulse CFG_ACK to top, clear flags, go READY.
- READY, SORT_START from top: forward SORT_START to children (non-leaf), phase counter <= 0, go SORT.
- SORT, every cycle, phase toggles. A child enters SORT one cycle after its parent, so adjacent levels are always in opposite phase.
- SORT, passive cycle (phase=1):
  - SWAP from top: center <= data_from_top, node_stable <= 0.
  - No initiation.
- SORT, active cycle (phase=0), non-leaf:
  - If left.key > self.key: pulse SWAP to left with data_to_left = center; center <= data_from_left.
  - Else if right.key < self.key: pulse SWAP to right likewise.
  - Else: no swap, node_stable <= 1.
  - Left has priority. Both registers update on the same edge, so the swap is atomic.
- Leaf active cycle: node_stable <= 1.
- SORT_STOP from top (either phase; takes precedence over a swap that cycle):
  - Non-leaf: forward SORT_STOP to children, go STOP_WAIT.
  - Leaf: pulse STOP_ACK, go READY.
- STOP_WAIT: aggregate STOP_ACK exactly like CFG_WAIT, then pulse STOP_ACK to top, go READY. Center retained.

Test Plan:
- Reset mid-CFG_WAIT (rst low for 1 cycle) -> all outputs 0/NOP immediately, state_o=IDLE, a later child CFG_ACK is ignored.
- Non-leaf, DIM=2: CONFIG data=3 -> next cycle CONFIG to both children with data 4, axis=1. Left CFG_ACK at t+2, right at t+5 -> single CFG_ACK to top at t+6.
- Leaf CONFIG data=0 -> CFG_ACK at t+1, state READY; a second CONFIG in READY is re-accepted.
- LOAD center (x=5,y=9), depth 0 (axis x), left child center x=8, right child x=12; SORT_START -> first active cycle: SWAP to left with data x=5, node center becomes x=8; next active cycle node_stable=1.
- left.key=10 > self=5 and right.key=2 < self=5 -> swaps with left only; swaps with right (key 2 < 10) two cycles later.
- SORT_STOP during an active cycle with a pending swap -> no SWAP issued, SORT_STOP forwarded, STOP_ACK to top one cycle after the last child STOP_ACK, center unchanged.
